fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch feeding decode through a 2-entry {inst, pc} queue.
// Define FETCH_STALL_CNT_EN to add the saturating stall_cnt output.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic [31:0]       data0_q, data0_d, data1_q, data1_d;
  logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic [2:0]        pending_s;

  assign inst_valid = (count_q != 2'd0);
  assign inst_data  = data0_q;
  assign inst_pc    = pc0_q;
  assign pop_s      = inst_valid && inst_ready;
  // A response returning in a redirect cycle belongs to the old path and is dropped.
  assign push_s     = inflight_q && !redirect_valid;
  // Pop never exceeds occupancy, so this cannot underflow.
  assign pending_s  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s    = (state_q == ST_RUN) && !redirect_valid && (pending_s < 3'd2);
  assign imem_en    = issue_s;
  assign imem_addr  = issue_s ? fetch_pc_q : '0;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   state_d = redirect_valid ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = redirect_valid ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  // fetch pointer and in-flight tracking
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    inflight_d = issue_s;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue_s) begin
      fetch_pc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      issue_pc_d = fetch_pc_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // queue update: redirect flushes, otherwise shift on pop and append on push
  always_comb begin
    count_d = count_q;
    data0_d = data0_q;
    data1_d = data1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    if (redirect_valid) begin
      count_d = 2'd0;
      data0_d = '0;
      pc0_d   = '0;
    end else begin
      case ({push_s, pop_s})
        2'b01: begin
          data0_d = data1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_d = imem_rdata;
            pc0_d   = issue_pc_q;
          end else begin
            data1_d = imem_rdata;
            pc1_d   = issue_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            data0_d = imem_rdata;
            pc0_d   = issue_pc_q;
          end else begin
            data0_d = data1_q;
            pc0_d   = pc1_q;
            data1_d = imem_rdata;
            pc1_d   = issue_pc_q;
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      data0_q    <= '0;
      data1_q    <= '0;
      pc0_q      <= '0;
      pc1_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // stall counter: cleared by redirect, saturating increment on back-pressure
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (redirect_valid) begin
      stall_cnt_d = 16'h0000;
    end else if (inst_valid && !inst_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed redirect/wrap sequences and a random run
// checked by a transaction-level scoreboard of the delivered program order.
module tb_fetch_unit;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0000_0000;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = 16'h0000;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst_data;
  logic [AW-1:0] inst_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  int pops = 0;

  logic [AW-1:0] exp_del = 16'h0000;
  logic [AW-1:0] exp_iss = 16'h0000;
  int            outstanding = 0;
  logic          prev_rv = 1'b0;
  logic          prev_hold = 1'b0;
  logic [AW-1:0] hold_pc;
  logic [31:0]   hold_data;
  logic [AW-1:0] delivered[$];

  typedef struct {
    logic rst; logic rdy; logic rv; logic [AW-1:0] rpc;
    logic en; logic [AW-1:0] addr; logic vld; logic [AW-1:0] pc;
  } vec_t;
  vec_t tbl [0:20];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return {16'h0000, a} + 32'hA000_0000;
  endfunction

  // memory: answers one cycle after each request
  always @(posedge clk) imem_rdata <= imem_en ? word(imem_addr) : 32'h5A5A_5A5A;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // one cycle: drive inputs at negedge, observe, update the scoreboard
  task automatic apply(input logic rst, input logic rdy, input logic rv, input logic [AW-1:0] rpc);
    logic pop;
    @(negedge clk);
    rst_n = rst; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    if (!rst) begin
      exp_del = 16'h0000; exp_iss = 16'h0000; outstanding = 0;
      prev_rv = 1'b0; prev_hold = 1'b0;
      return;
    end
    if (prev_rv) chk("valid_after_redirect", inst_valid, 1'b0);
    if (prev_hold) begin
      chk("hold_valid", inst_valid, 1'b1);
      chk("hold_pc", inst_pc, hold_pc);
      chk("hold_data", inst_data, hold_data);
    end
    pop = inst_valid && rdy;
    if (pop) begin
      chk("deliver_pc", inst_pc, exp_del);
      chk("deliver_data", inst_data, word(inst_pc));
      delivered.push_back(inst_pc);
      exp_del = exp_del + 16'h0001;
      outstanding--;
      pops++;
    end
    if (imem_en) begin
      chk("issue_addr", imem_addr, exp_iss);
      chk("issue_during_redirect", rv, 1'b0);
      exp_iss = exp_iss + 16'h0001;
      outstanding++;
    end
    chk("outstanding_range", (outstanding >= 0 && outstanding <= 2), 1'b1);
    if (rv) begin
      exp_del = rpc; exp_iss = rpc; outstanding = 0;
    end
    prev_rv = rv;
    prev_hold = inst_valid && !rdy && !rv;
    hold_pc = inst_pc;
    hold_data = inst_data;
  endtask

  initial begin
    int n;
    int cnt;
    logic r_rst, r_rdy, r_rv;
    logic [AW-1:0] r_pc;

    //           rst   rdy   rv    rpc       en    addr      vld   pc
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0000};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0001};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0002};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0003};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000};
    for (int i = 12; i <= 16; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0000};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0001};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0002};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0003};

    for (int i = 0; i <= 20; i++) begin
      apply(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("tbl%0d_en", i), imem_en, tbl[i].en);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_data", i), inst_data, tbl[i].vld ? word(tbl[i].pc) : 32'h0000_0000);
    end

    // redirect while the queue holds pc 5,6
    apply(1'b0, 1'b1, 1'b0, 16'h0000);
    n = 0;
    while (exp_del != 16'h0005 && n < 50) begin
      apply(1'b1, 1'b1, 1'b0, 16'h0000);
      n++;
    end
    chk("seq031_reach", n < 50, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 16'h0000);
    apply(1'b1, 1'b0, 1'b1, 16'h0040);
    chk("seq031_head", inst_pc, 16'h0005);
    delivered.delete();
    apply(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("seq031_flush_en", imem_en, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("seq031_first_en", imem_en, 1'b1);
    chk("seq031_first_addr", imem_addr, 16'h0040);
    for (int i = 0; i < 6; i++) apply(1'b1, 1'b1, 1'b0, 16'h0000);
    cnt = 0;
    foreach (delivered[k]) if (delivered[k] >= 16'h0005 && delivered[k] <= 16'h0007) cnt++;
    chk("seq031_killed", cnt, 0);
    chk("seq031_count", delivered.size() >= 2, 1'b1);
    if (delivered.size() >= 2) begin
      chk("seq031_pc0", delivered[0], 16'h0040);
      chk("seq031_pc1", delivered[1], 16'h0041);
    end

    // redirect coinciding with the pop of pc 3
    apply(1'b0, 1'b1, 1'b0, 16'h0000);
    delivered.delete();
    for (int i = 0; i < 6; i++) apply(1'b1, 1'b1, 1'b0, 16'h0000);
    apply(1'b1, 1'b1, 1'b1, 16'h0080);
    chk("seq032_pop_pc", inst_pc, 16'h0003);
    for (int i = 0; i < 6; i++) apply(1'b1, 1'b1, 1'b0, 16'h0000);
    cnt = 0;
    foreach (delivered[k]) if (delivered[k] == 16'h0003) cnt++;
    chk("seq032_once", cnt, 1);
    chk("seq032_count", delivered.size() >= 5, 1'b1);
    if (delivered.size() >= 5) chk("seq032_next", delivered[4], 16'h0080);

    // address wrap after a redirect to all-ones
    apply(1'b1, 1'b1, 1'b1, 16'hFFFF);
    delivered.delete();
    for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("seq033_count", delivered.size() >= 3, 1'b1);
    if (delivered.size() >= 3) begin
      chk("seq033_pc0", delivered[0], 16'hFFFF);
      chk("seq033_pc1", delivered[1], 16'h0000);
      chk("seq033_pc2", delivered[2], 16'h0001);
    end

`ifdef FETCH_STALL_CNT_EN
    apply(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("stall_reset", stall_cnt, 16'h0000);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 1'b0, 16'h0000);
    apply(1'b1, 1'b0, 1'b1, 16'h0010);
    chk("stall_ten", stall_cnt, 16'd10);
    apply(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("stall_cleared", stall_cnt, 16'h0000);
`endif

    // random traffic against the scoreboard
    apply(1'b0, 1'b1, 1'b0, 16'h0000);
    pops = 0;
    for (int i = 0; i < 1500; i++) begin
      r_rst = ($urandom_range(0, 299) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 65535));
      apply(r_rst, r_rdy, r_rv, r_pc);
    end
    chk("random_progress", pops > 300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
